// File: rtl/layer_sequencer.sv
// Sequences up to NUM_STAGES datapath units in index order over a programmable
// number of iterations, with per-stage timeout and a sticky error flag.
module layer_sequencer #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned ITER_W     = 8,
  parameter int unsigned TIMEOUT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_STAGES-1:0] stage_enable,
  input  logic [ITER_W-1:0]     num_iters,
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic                  busy,
  output logic                  done_all,
  output logic                  error,
  output logic [ITER_W-1:0]     iter_count
);

  localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t                state, state_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic [ITER_W-1:0]     iters_q, iters_d;
  logic [TIMEOUT_W-1:0]  limit_q, limit_d;
  logic [TIMEOUT_W-1:0]  tcnt_q, tcnt_d;
  logic [IDX_W-1:0]      cur_q, cur_d;
  logic [NUM_STAGES-1:0] stage_start_d;
  logic                  busy_d, done_all_d, error_d;
  logic [ITER_W-1:0]     iter_count_d;

  logic [IDX_W-1:0]      low_in, low_q, hi_q;
  logic                  has_hi;
  logic [ITER_W-1:0]     iter_inc;

  // Priority scans: lowest enabled stage (new and latched mask), next higher enabled stage.
  always_comb begin
    low_in = '0;
    low_q  = '0;
    hi_q   = '0;
    has_hi = 1'b0;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      if (stage_enable[i]) low_in = IDX_W'(i);
      if (mask_q[i]) low_q = IDX_W'(i);
      if (mask_q[i] && (i > int'(cur_q))) begin
        hi_q   = IDX_W'(i);
        has_hi = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state;
    mask_d        = mask_q;
    iters_d       = iters_q;
    limit_d       = limit_q;
    tcnt_d        = tcnt_q;
    cur_d         = cur_q;
    stage_start_d = stage_start;
    busy_d        = busy;
    done_all_d    = 1'b0;
    error_d       = error;
    iter_count_d  = iter_count;
    iter_inc      = iter_count + ITER_W'(1);

    case (state)
      IDLE: begin
        if (start) begin
          mask_d       = stage_enable;
          iters_d      = num_iters;
          limit_d      = timeout_limit;
          error_d      = 1'b0;
          iter_count_d = '0;
          tcnt_d       = '0;
          busy_d       = 1'b1;
          if ((stage_enable == '0) || (num_iters == '0)) begin
            state_d    = DONE;
            done_all_d = 1'b1;
          end else begin
            state_d       = RUN;
            cur_d         = low_in;
            stage_start_d = NUM_STAGES'(1) << low_in;
          end
        end
      end
      RUN: begin
        if (stage_done[cur_q]) begin
          stage_start_d = '0;
          tcnt_d        = '0;
          if (has_hi) begin
            state_d = GAP;
            cur_d   = hi_q;
          end else begin
            iter_count_d = iter_inc;
            if (iter_inc == iters_q) begin
              state_d    = DONE;
              done_all_d = 1'b1;
            end else begin
              state_d = GAP;
              cur_d   = low_q;
            end
          end
        end else if ((limit_q != '0) && (tcnt_q == limit_q - TIMEOUT_W'(1))) begin
          stage_start_d = '0;
          tcnt_d        = '0;
          error_d       = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end else if (limit_q != '0) begin
          tcnt_d = tcnt_q + TIMEOUT_W'(1);
        end
      end
      GAP: begin
        state_d       = RUN;
        stage_start_d = NUM_STAGES'(1) << cur_q;
        tcnt_d        = '0;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mask_q      <= '0;
      iters_q     <= '0;
      limit_q     <= '0;
      tcnt_q      <= '0;
      cur_q       <= '0;
      stage_start <= '0;
      busy        <= 1'b0;
      done_all    <= 1'b0;
      error       <= 1'b0;
      iter_count  <= '0;
    end else begin
      state       <= state_d;
      mask_q      <= mask_d;
      iters_q     <= iters_d;
      limit_q     <= limit_d;
      tcnt_q      <= tcnt_d;
      cur_q       <= cur_d;
      stage_start <= stage_start_d;
      busy        <= busy_d;
      done_all    <= done_all_d;
      error       <= error_d;
      iter_count  <= iter_count_d;
    end
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Parametrised top-level sequencer for the accelerator datapath. It runs up to NUM_STAGES processing units (matmul, norm, activation, pool, ...) in fixed index order. Each stage has a start/done handshake, and the enabled chain repeats for a programmable number of iterations (tiles). It adds per-stage timeout detection and a sticky error flag, and sits between the host/config registers and the stage units.

## Interface
Parameters:
- NUM_STAGES, 4: number of stage handshake channels; index 0 runs first.
- ITER_W, 8: width of the iteration count.
- TIMEOUT_W, 16: width of the timeout limit and counter.

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to run; sampled only in IDLE.
- stage_enable  in  NUM_STAGES  stage mask; latched on accepted start.
- num_iters  in  ITER_W  iterations to run; latched on accepted start.
- timeout_limit  in  TIMEOUT_W  maximum cycles per stage; 0 disables; latched on accepted start.
- stage_start  out  NUM_STAGES  one-hot or zero; level held until that stage's done.
- stage_done  in  NUM_STAGES  per-stage done; only the active stage's bit is observed.
- busy  out  1  high whenever state is not IDLE.
- done_all  out  1  one-cycle pulse on normal completion.
- error  out  1  sticky timeout flag.
- iter_count  out  ITER_W  number of completed iterations in the current or last run.

## Operation
- States: IDLE, RUN, GAP, DONE.
- Reset value of every output: 0. Reset puts the block in IDLE, clears latched config, timeout counter and error. Reset mid-run has the same effect; stage_start drops on the next edge.
- IDLE, start=1: error and iter_count are cleared, and inputs are latched.
  - If the mask is 0 or num_iters=0: go to DONE; no stage is started.
  - Otherwise: stage_start[k]=1 for the lowest enabled k; go to RUN.
- IDLE, start=0: stay in IDLE.
- start while busy is ignored. Changes to stage_enable, num_iters or timeout_limit mid-run have no effect.
- RUN, active stage k: stage_start[k] is held high, because stage units use it as a level enable and reset.
- RUN, stage_done[k]=1: stage_start goes to 0 next cycle.
  - If a higher enabled index j exists: go to GAP, next stage j.
  - Else iter_count increments. If the new value equals num_iters, go to DONE; else go to GAP with next stage = lowest enabled index.
- stage_done bits of inactive stages are ignored in every state.
- GAP: all stage_start bits are 0 for exactly one cycle. Then stage_start[next]=1 and the state returns to RUN.
- DONE: done_all=1 for one cycle, busy=1, then IDLE.
- Timeout, only when the latched limit L≠0:
  - The counter is 0 in the first cycle stage_start[k] is high and increments every RUN cycle.
  - If the counter is L−1 and stage_done[k]=0: next cycle stage_start=0, error=1, state IDLE, busy=0. done_all is not pulsed and iter_count is frozen.
  - stage_done[k]=1 in that same cycle wins; no error.
- error stays high until reset or the next accepted start.
- Arithmetic: iter_count and the timeout counter are unsigned and never wrap, because termination checks precede overflow. num_iters=2^ITER_W−1 is legal.

## Timing
- Start accepted at edge T: busy=1 and stage_start[first]=1 during cycle T+1.
- Stage done sampled at edge D, next stage exists: stage_start=0 in D+1 (GAP); next stage_start=1 in D+2.
- Last done sampled at edge D: done_all=1 and iter_count final in D+1; busy=0 in D+2.
- Empty mask or num_iters=0 accepted at T: done_all=1 in T+1; busy=0 in T+2.
- Minimum per-stage occupancy is 1 cycle, when done is returned in the first start cycle.
- Timeout: stage_start stays high for exactly L cycles; error=1 the following cycle.

## Test plan
- Mask 4'b0101, num_iters=1, each done 3 cycles after start: stage_start goes 0001, gap, 0100. done_all pulses once, iter_count=1, error=0.
- Mask 4'b1111, num_iters=3, done returned in the first start cycle: 12 stage activations with a one-cycle gap between each. Stage 3 followed by stage 0 between iterations. iter_count reaches 3, done_all is a single pulse.
- Mask 0 with num_iters=5, then mask 4'b0001 with num_iters=0: in both runs done_all pulses at T+1, stage_start is never asserted, iter_count=0.
- timeout_limit=4, stage 1 never done: stage_start[1] high for 4 cycles, then error=1, busy=0, no done_all. A new start clears error. Separately, done on the 4th cycle completes without error.
- Spurious stage_done on inactive bits, start pulses mid-run, and mask changes mid-run: sequence and iter_count are unaffected.
- reset asserted while stage_start[2]=1: all outputs are 0 next cycle. A subsequent start runs normally from stage 0.
